skyhop_game_ctrl: RTL and testbench

Frame-synchronous game-state controller for SkyHop. It sits between the VGA timing block (vs), the board switches, and the sprite/renderer datapath. It sequences IDLE/PLAY/PAUSE/OVER, keeps the BCD score and the lives count, gates collision events, and drives the status LED. Renderers read the `state`, `score` and `lives` outputs to choose what to draw.

---
 rtl/skyhop_game_ctrl_if.sv | 33 +++
 rtl/skyhop_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_skyhop_game_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/skyhop_game_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | Module : skyhop_game_ctrl_if                                             |
// | Desc   : Board/renderer-side signal bundle for the SkyHop game control.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface skyhop_game_ctrl_if;
    logic        vs;
    logic        start;
    logic        pause;
    logic        collision;
    logic        landed;
    logic [1:0]  state;
    logic        frame_tick;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [15:0] hiscore;
    logic        led;

    // master = board/renderer side, slave = the game controller
    modport master (
        output vs, start, pause, collision, landed,
        input  state, frame_tick, score, lives, hiscore, led
    );

    modport slave (
        input  vs, start, pause, collision, landed,
        output state, frame_tick, score, lives, hiscore, led
    );
endinterface

`default_nettype wire

// File: rtl/skyhop_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module : skyhop_game_ctrl                                                |
// | Desc   : Frame-synchronous SkyHop state/score/lives/LED controller.      |
// |          Optional high-score register enabled by SKYHOP_HISCORE_EN.      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module skyhop_game_ctrl #(
    parameter int FRAME_DIV  = 60,
    parameter int LIVES      = 3,
    parameter int INV_FRAMES = 90
) (
    input  wire logic             clk,
    input  wire logic             rst,
    skyhop_game_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int                c_BW        = ($clog2(FRAME_DIV) > 3) ? $clog2(FRAME_DIV) : 3;
    localparam logic [c_BW-1:0]   c_PAUSE_LIM = c_BW'(FRAME_DIV / 2 - 1);
    localparam logic [c_BW-1:0]   c_OVER_LIM  = c_BW'(7);
    localparam logic [1:0]        c_LIVES     = 2'(LIVES);
    localparam logic [7:0]        c_INV       = 8'(INV_FRAMES);

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic              r_tick;
    logic [15:0]       r_score;
    logic [1:0]        r_lives;
    logic [7:0]        r_inv;
    logic [c_BW-1:0]   r_blink;
    logic              r_led;
    logic              w_hit;
    logic [15:0]       w_score_next;

    // BCD +1 with per-digit carry; holds at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign w_hit        = bus.collision && (r_inv == 8'd0);
    assign w_score_next = (r_state == S_PLAY && bus.landed) ? bcd_inc(r_score) : r_score;

    // vs crosses into clk domain here; presetting to 1 avoids a spurious tick out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= bus.vs;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= r_prev & ~r_sync2;
        end
    end

`ifdef SKYHOP_HISCORE_EN
    logic [15:0] r_hiscore;
    assign bus.hiscore = r_hiscore;
`else
    assign bus.hiscore = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_score   <= 16'h0000;
            r_lives   <= 2'd0;
            r_inv     <= 8'd0;
            r_blink   <= '0;
            r_led     <= 1'b0;
`ifdef SKYHOP_HISCORE_EN
            r_hiscore <= 16'h0000;
`endif
        end else begin
            r_score <= w_score_next;
            if (r_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_PLAY;
                            r_score <= 16'h0000;
                            r_lives <= c_LIVES;
                            r_inv   <= 8'd0;
                            r_blink <= '0;
                            r_led   <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (r_inv != 8'd0) begin
                            r_inv <= r_inv - 8'd1;
                        end
                        if (w_hit && r_lives == 2'd1) begin
                            r_state <= S_OVER;
                            r_lives <= 2'd0;
                            r_blink <= '0;
                            r_led   <= 1'b1;
`ifdef SKYHOP_HISCORE_EN
                            if (w_score_next > r_hiscore) begin
                                r_hiscore <= w_score_next;
                            end
`endif
                        end else begin
                            if (w_hit) begin
                                r_lives <= r_lives - 2'd1;
                                r_inv   <= c_INV;
                            end
                            if (bus.pause) begin
                                r_state <= S_PAUSE;
                                r_blink <= '0;
                                r_led   <= 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!bus.pause) begin
                            r_state <= S_PLAY;
                            r_blink <= '0;
                            r_led   <= 1'b1;
                        end else if (r_blink == c_PAUSE_LIM) begin
                            r_blink <= '0;
                            r_led   <= ~r_led;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                    default: begin
                        // start must be released before returning to IDLE
                        if (!bus.start) begin
                            r_state <= S_IDLE;
                            r_blink <= '0;
                            r_led   <= 1'b0;
                        end else if (r_blink == c_OVER_LIM) begin
                            r_blink <= '0;
                            r_led   <= ~r_led;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.frame_tick = r_tick;
    assign bus.score      = r_score;
    assign bus.lives      = r_lives;
    assign bus.led        = r_led;

endmodule

`default_nettype wire

// File: tb/tb_skyhop_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module : tb_skyhop_game_ctrl                                             |
// | Desc   : Directed self-checking bench for skyhop_game_ctrl.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_skyhop_game_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   fall_cyc;

    skyhop_game_ctrl_if bus ();

    skyhop_game_ctrl #(
        .FRAME_DIV  (60),
        .LIVES      (3),
        .INV_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // vs: low for 20 clk every 200 clk, changed on the falling clock edge
    initial begin
        bus.vs   = 1'b1;
        fall_cyc = 0;
        forever begin
            repeat (180) @(negedge clk);
            bus.vs   = 1'b0;
            fall_cyc = cyc;
            repeat (20) @(negedge clk);
            bus.vs   = 1'b1;
        end
    end

    // returns one cycle after the frame_tick, when state/lives/led have updated
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.frame_tick && n < 1000);
        if (!bus.frame_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_landed(input int count);
        for (int i = 0; i < count; i++) begin
            bus.landed = 1'b1;
            @(posedge clk);
            #1;
            bus.landed = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int t0;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.score !== 16'h0000 || bus.lives !== 2'd0 ||
            bus.led !== 1'b0 || bus.frame_tick !== 1'b0 || bus.hiscore !== 16'h0000) begin
            errors++;
            $display("FAIL reset_vals: state=%0d score=%h lives=%0d led=%b tick=%b hi=%h, required 0/0000/0/0/0/0000",
                     bus.state, bus.score, bus.lives, bus.led, bus.frame_tick, bus.hiscore);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int f = 0; f < 2; f++) begin
            int n;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!bus.frame_tick && n < 1000);
            checks++;
            if (cyc - fall_cyc !== 3) begin
                errors++;
                $display("FAIL tick_latency: frame %0d tick at %0d clk after vs fall, required 3", f, cyc - fall_cyc);
            end
            if (f == 1) begin
                checks++;
                if (cyc - t0 !== 200) begin
                    errors++;
                    $display("FAIL tick_period: %0d clk between ticks, required 200", cyc - t0);
                end
            end
            t0 = cyc;
            @(posedge clk);
            #1;
            checks++;
            if (bus.frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL tick_width: frame_tick=%b one cycle later, required 0", bus.frame_tick);
            end
        end
    endtask

    task automatic test_start();
        bus.start = 1'b1;
        wait_tick();
        checks++;
        if (bus.state !== 2'd1 || bus.lives !== 2'd3 || bus.led !== 1'b1 || bus.score !== 16'h0000) begin
            errors++;
            $display("FAIL start_game: state=%0d lives=%0d led=%b score=%h, required 1/3/1/0000",
                     bus.state, bus.lives, bus.led, bus.score);
        end
    endtask

    task automatic test_pause();
        bus.pause = 1'b1;
        wait_tick();
        checks++;
        if (bus.state !== 2'd2 || bus.led !== 1'b1) begin
            errors++;
            $display("FAIL pause_enter: state=%0d led=%b, required 2/1", bus.state, bus.led);
        end
        pulse_landed(3);
        checks++;
        if (bus.score !== 16'h0000) begin
            errors++;
            $display("FAIL pause_landed: score=%h, required 0000", bus.score);
        end
        for (int k = 1; k <= 30; k++) begin
            wait_tick();
            if (k == 29 || k == 30) begin
                checks++;
                if (bus.led !== (k == 29 ? 1'b1 : 1'b0) || bus.state !== 2'd2) begin
                    errors++;
                    $display("FAIL pause_blink: after %0d ticks led=%b state=%0d, required led=%b state=2",
                             k, bus.led, bus.state, (k == 29));
                end
            end
        end
        bus.pause = 1'b0;
        wait_tick();
        checks++;
        if (bus.state !== 2'd1 || bus.led !== 1'b1) begin
            errors++;
            $display("FAIL pause_exit: state=%0d led=%b, required 1/1", bus.state, bus.led);
        end
    endtask

    task automatic test_scoring(input int count, input logic [15:0] exp, input string name);
        pulse_landed(count);
        checks++;
        if (bus.score !== exp) begin
            errors++;
            $display("FAIL score_%s: score=%h, required %h", name, bus.score, exp);
        end
    endtask

    task automatic test_lives(input logic [15:0] exp_score, input logic [15:0] exp_hi);
        logic [1:0] exp_lives [0:6];
        exp_lives = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0};
        bus.collision = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            wait_tick();
            checks++;
            if (bus.lives !== exp_lives[k] || bus.state !== (k == 6 ? 2'd3 : 2'd1)) begin
                errors++;
                $display("FAIL lives_frame_n+%0d: lives=%0d state=%0d, required %0d/%0d",
                         k, bus.lives, bus.state, exp_lives[k], (k == 6 ? 3 : 1));
            end
        end
        bus.collision = 1'b0;
        checks++;
        if (bus.led !== 1'b1 || bus.score !== exp_score) begin
            errors++;
            $display("FAIL over_entry: led=%b score=%h, required 1/%h", bus.led, bus.score, exp_score);
        end
        wait_tick();
        checks++;
        if (bus.state !== 2'd3) begin
            errors++;
            $display("FAIL over_hold_start: state=%0d, required 3", bus.state);
        end
        bus.start = 1'b0;
        wait_tick();
        checks++;
        if (bus.state !== 2'd0 || bus.led !== 1'b0 || bus.hiscore !== exp_hi) begin
            errors++;
            $display("FAIL over_release: state=%0d led=%b hiscore=%h, required 0/0/%h",
                     bus.state, bus.led, bus.hiscore, exp_hi);
        end
    endtask

    task automatic test_reset_midgame();
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.score !== 16'h0000 || bus.lives !== 2'd0 ||
            bus.led !== 1'b0 || bus.hiscore !== 16'h0000) begin
            errors++;
            $display("FAIL reset_midgame: state=%0d score=%h lives=%0d led=%b hi=%h, required all 0",
                     bus.state, bus.score, bus.lives, bus.led, bus.hiscore);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [15:0] hi1;
    logic [15:0] hi2;

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.collision = 1'b0;
        bus.landed    = 1'b0;
`ifdef SKYHOP_HISCORE_EN
        hi1 = 16'h0042;
        hi2 = 16'h0042;
`else
        hi1 = 16'h0000;
        hi2 = 16'h0000;
`endif
        test_reset();
        test_start();
        test_pause();
        test_scoring(12, 16'h0012, "12");
        test_scoring(30, 16'h0042, "42");
        test_lives(16'h0042, hi1);
        test_start();
        test_scoring(17, 16'h0017, "17");
        test_lives(16'h0017, hi2);
        test_start();
        test_scoring(99, 16'h0099, "99");
        test_scoring(1, 16'h0100, "carry");
        test_scoring(9899, 16'h9999, "9999");
        test_scoring(1, 16'h9999, "saturate");
        test_reset_midgame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
